// File: rtl/tea_dispatch_ctrl.sv
// Round-robin dispatcher for a bank of iterative TEA decryptor cores.
// Blocks go out to cores in rotation; plaintext comes back strictly in input order.
module tea_dispatch_ctrl #(
  parameter int N_CORES = 4,
  parameter int PW      = $clog2(N_CORES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            in_data,
  output logic [N_CORES-1:0]     core_start,
  output logic [63:0]            core_data,
  input  logic [N_CORES-1:0]     core_done,
  input  logic [64*N_CORES-1:0]  core_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_data,
  output logic [PW:0]            in_flight,
  output logic                   err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FULL = 2'd2
  } slot_e;

  slot_e              r_slot [N_CORES];
  logic [63:0]        r_res  [N_CORES];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [PW:0]        r_in_flight;
  logic [N_CORES-1:0] r_core_start;
  logic [63:0]        r_core_data;
  logic               r_err;

  logic               w_accept;
  logic               w_release;
  logic [N_CORES-1:0] w_start_onehot;

  // Handshake outputs depend only on registered slot state; no same-cycle bypass.
  assign in_ready  = ena & (r_slot[r_wr_ptr] == S_IDLE);
  assign out_valid = ena & (r_slot[r_rd_ptr] == S_FULL);
  assign out_data  = r_res[r_rd_ptr];

  assign w_accept       = in_valid & in_ready;
  assign w_release      = out_valid & out_ready;
  assign w_start_onehot = {{(N_CORES-1){1'b0}}, 1'b1} << r_wr_ptr;

  assign core_start = r_core_start;
  assign core_data  = r_core_data;
  assign in_flight  = r_in_flight;
  assign err        = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the result registers are reset because their contents are visible
      // on out_data; a small register file like this costs little to clear.
      for (int i = 0; i < N_CORES; i++) begin
        r_slot[i] <= S_IDLE;
        r_res[i]  <= '0;
      end
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_in_flight  <= '0;
      r_core_start <= '0;
      r_core_data  <= '0;
      r_err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every slot update below
      // reads the state from before this edge regardless of statement order.
      r_core_start <= w_accept ? w_start_onehot : '0;
      if (w_accept) begin
        r_core_data <= in_data;
      end

      // Done capture runs independently of ena; a done on a non-BUSY slot is a protocol error.
      for (int i = 0; i < N_CORES; i++) begin
        if (core_done[i]) begin
          if (r_slot[i] == S_BUSY) begin
            r_res[i]  <= core_out[64*i +: 64];
            r_slot[i] <= S_FULL;
          end else begin
            r_err <= 1'b1;
          end
        end
      end

      if (w_accept) begin
        r_slot[r_wr_ptr] <= S_BUSY;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end

      // Accept needs IDLE and release needs FULL, so both never hit one slot together.
      if (w_release) begin
        r_slot[r_rd_ptr] <= S_IDLE;
        r_rd_ptr         <= r_rd_ptr + 1'b1;
      end

      case ({w_accept, w_release})
        2'b10:   r_in_flight <= r_in_flight + 1'b1;
        2'b01:   r_in_flight <= r_in_flight - 1'b1;
        default: r_in_flight <= r_in_flight;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_dispatch_ctrl.sv
// Scoreboard bench for tea_dispatch_ctrl: expected plaintext is queued at accept
// time and a negedge monitor pops and compares every released block.
module tb_tea_dispatch_ctrl;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic [N-1:0]  core_start;
  logic [63:0]   core_data;
  logic [N-1:0]  core_done;
  logic [64*N-1:0] core_out;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_data;
  logic [2:0]    in_flight;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q [$];
  logic [63:0] tb_res [N];
  logic [1:0]  tb_wr;

  tea_dispatch_ctrl #(.N_CORES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .core_start (core_start),
    .core_data  (core_data),
    .core_done  (core_done),
    .core_out   (core_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .in_flight  (in_flight),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0)
        check("spurious_out_valid", {63'b0, out_valid}, 64'd0);
      else
        check("out_data", out_data, exp_q.pop_front());
    end
  end

  task automatic send(input logic [63:0] d, input logic [63:0] r);
    int n;
    logic [N-1:0] exp_start;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      check("in_ready_timeout", {63'b0, in_ready}, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(r);
    tb_res[tb_wr] = r;
    exp_start = 4'b0001 << tb_wr;
    tb_wr = tb_wr + 2'd1;
    #1;
    in_valid = 1'b0;
    check("core_start", {60'b0, core_start}, {60'b0, exp_start});
    check("core_data", core_data, d);
  endtask

  task automatic pulse_done(input logic [N-1:0] mask);
    core_done = mask;
    for (int i = 0; i < N; i++)
      core_out[64*i +: 64] = mask[i] ? tb_res[i] : 64'h5A5A_5A5A_5A5A_5A5A;
    @(posedge clk); #1;
    core_done = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    tb_wr = 2'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    ena       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    core_done = '0;
    core_out  = '0;
    out_ready = 1'b1;
    tb_wr     = 2'd0;
    for (int i = 0; i < N; i++) tb_res[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset / idle
    check("idle_in_ready",   {63'b0, in_ready},  64'd1);
    check("idle_out_valid",  {63'b0, out_valid}, 64'd0);
    check("idle_core_start", {60'b0, core_start}, 64'd0);
    check("idle_in_flight",  {61'b0, in_flight}, 64'd0);
    check("idle_err",        {63'b0, err},       64'd0);

    // Single block, core 0 latency 32
    send(64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_00C0_FFEE);
    @(posedge clk); #1;
    check("single_start_cleared", {60'b0, core_start}, 64'd0);
    check("single_in_flight_1",   {61'b0, in_flight},  64'd1);
    repeat (30) @(posedge clk);
    #1;
    check("single_no_early_valid", {63'b0, out_valid}, 64'd0);
    pulse_done(4'b0001);
    check("single_valid_after_done", {63'b0, out_valid}, 64'd1);
    check("single_out_data", out_data, 64'hDEAD_BEEF_00C0_FFEE);
    check("single_in_flight_pre", {61'b0, in_flight}, 64'd1);
    @(posedge clk); #1;
    check("single_in_flight_0", {61'b0, in_flight}, 64'd0);
    check("single_valid_one_cycle", {63'b0, out_valid}, 64'd0);

    // Out-of-order completion: cores finish 3,1,0,2
    do_reset();
    send(64'hAAAA_0000_0000_0001, 64'h1111_1111_1111_1111);
    send(64'hBBBB_0000_0000_0002, 64'h2222_2222_2222_2222);
    send(64'hCCCC_0000_0000_0003, 64'h3333_3333_3333_3333);
    send(64'hDDDD_0000_0000_0004, 64'h4444_4444_4444_4444);
    pulse_done(4'b1000);
    check("ooo_hold_after_3", {63'b0, out_valid}, 64'd0);
    pulse_done(4'b0010);
    check("ooo_hold_after_1", {63'b0, out_valid}, 64'd0);
    pulse_done(4'b0001);
    check("ooo_valid_after_0", {63'b0, out_valid}, 64'd1);
    pulse_done(4'b0100);
    wait_drain();
    @(posedge clk); #1;
    check("ooo_in_flight", {61'b0, in_flight}, 64'd0);

    // Full and backpressure, all four dones in one cycle
    out_ready = 1'b0;
    send(64'h0000_0000_0000_00E0, 64'hE0E0_E0E0_0000_0000);
    send(64'h0000_0000_0000_00E1, 64'hE1E1_E1E1_0000_0001);
    send(64'h0000_0000_0000_00E2, 64'hE2E2_E2E2_0000_0002);
    send(64'h0000_0000_0000_00E3, 64'hE3E3_E3E3_0000_0003);
    check("full_in_ready",  {63'b0, in_ready},  64'd0);
    check("full_in_flight", {61'b0, in_flight}, 64'd4);
    pulse_done(4'b1111);
    check("full_out_valid", {63'b0, out_valid}, 64'd1);
    check("full_head_data", out_data, 64'hE0E0_E0E0_0000_0000);
    out_ready = 1'b1;
    check("full_ready_same_cycle", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("full_ready_next_cycle", {63'b0, in_ready},  64'd1);
    check("full_in_flight_3",      {61'b0, in_flight}, 64'd3);
    send(64'h0000_0000_0000_00E4, 64'hE4E4_E4E4_0000_0004);
    out_ready = 1'b1;
    pulse_done(4'b0001);
    wait_drain();
    @(posedge clk); #1;
    check("full_drained_in_flight", {61'b0, in_flight}, 64'd0);

    // Spurious done on an IDLE slot
    pulse_done(4'b0100);
    check("spur_err",       {63'b0, err},       64'd1);
    check("spur_in_flight", {61'b0, in_flight}, 64'd0);
    check("spur_out_valid", {63'b0, out_valid}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("spur_err_sticky", {63'b0, err}, 64'd1);

    // Enable low with two blocks BUSY (slots 1 and 2)
    send(64'h0000_0000_0000_0F01, 64'hF1F1_0000_0000_0001);
    send(64'h0000_0000_0000_0F02, 64'hF2F2_0000_0000_0002);
    ena = 1'b0;
    #1;
    check("ena0_in_ready", {63'b0, in_ready}, 64'd0);
    pulse_done(4'b0110);
    check("ena0_out_valid",  {63'b0, out_valid}, 64'd0);
    check("ena0_in_flight",  {61'b0, in_flight}, 64'd2);
    repeat (3) @(posedge clk);
    #1;
    check("ena0_still_held", {63'b0, out_valid}, 64'd0);
    ena = 1'b1;
    #1;
    check("ena1_head_data", out_data, 64'hF1F1_0000_0000_0001);
    wait_drain();
    @(posedge clk); #1;
    check("ena1_in_flight", {61'b0, in_flight}, 64'd0);

    // Reset with three blocks in flight (slots 3, 0, 1)
    send(64'h0000_0000_0000_0C03, 64'hC3C3_0000_0000_0003);
    send(64'h0000_0000_0000_0C00, 64'hC0C0_0000_0000_0000);
    send(64'h0000_0000_0000_0C01, 64'hC1C1_0000_0000_0001);
    check("rst_pre_in_flight", {61'b0, in_flight}, 64'd3);
    rst = 1'b0;
    exp_q.delete();
    tb_wr = 2'd0;
    #1;
    check("rst_in_ready",   {63'b0, in_ready},   64'd1);
    check("rst_out_valid",  {63'b0, out_valid},  64'd0);
    check("rst_core_start", {60'b0, core_start}, 64'd0);
    check("rst_core_data",  core_data,           64'd0);
    check("rst_in_flight",  {61'b0, in_flight},  64'd0);
    check("rst_err",        {63'b0, err},        64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    pulse_done(4'b1000);
    check("post_rst_done_err", {63'b0, err},       64'd1);
    check("post_rst_no_valid", {63'b0, out_valid}, 64'd0);
    check("post_rst_in_flight", {61'b0, in_flight}, 64'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
